// File: rtl/onehot_encoder_arbiter.sv
// ----------------------------------------------------------------------------
// onehot_encoder_arbiter
//   Picks one requester out of a level-sensitive request vector, acknowledges
//   it with a one-cycle grant pulse and hands its binary index to a single
//   consumer over a valid/ready interface. The priority scheme is either
//   fixed, where the lowest index wins, or round-robin, where the search
//   starts at a pointer that rotates past each accepted requester. The output
//   stage is either registered, with one cycle of latency and full
//   throughput, or purely combinational.
//
// Parameters
//   WIDTH       number of request lines (>= 2, any value)
//   SPLIT       group size of the two-level priority search tree
//   MODE        0: fixed priority, 1: round-robin
//   REGISTERED  1: registered output stage, 0: combinational output
//
// Ports
//   clk      in   1          clock, rising edge
//   rst      in   1          synchronous active-high reset
//   dec_vld  in   WIDTH      request vector
//   dec_gnt  out  WIDTH      one-hot grant pulse for the accepted requester
//   enc_vld  out  1          encoded output valid
//   enc_rdy  in   1          consumer ready
//   enc_idx  out  WIDTH_LOG  index of the granted requester
// ----------------------------------------------------------------------------
module onehot_encoder_arbiter #(
   parameter int WIDTH      = 16,
   parameter int SPLIT      = 4,
   parameter int MODE       = 0,
   parameter int REGISTERED = 1,
   localparam int WIDTH_LOG = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     dec_vld,
   output logic [WIDTH-1:0]     dec_gnt,
   output logic                 enc_vld,
   input  logic                 enc_rdy,
   output logic [WIDTH_LOG-1:0] enc_idx
);

   localparam int unsigned NGRP = (WIDTH + SPLIT - 1) / SPLIT;
   localparam int unsigned PADW = NGRP * SPLIT;

   // Lowest set bit of v, returned as {found, index}. First level finds the
   // lowest bit inside each SPLIT-wide group, second level the lowest
   // non-empty group. The vector is zero-padded to a whole number of groups.
   function automatic logic [WIDTH_LOG:0] first_set(input logic [WIDTH-1:0] v);
      logic [PADW-1:0]      vp;
      logic [NGRP-1:0]      grp_any;
      logic [WIDTH_LOG-1:0] grp_idx [NGRP];
      logic                 found;
      logic [WIDTH_LOG-1:0] idx;
      vp      = PADW'(v);
      grp_any = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned g = 0; g < NGRP; g++) begin
         grp_idx[g] = '0;
         for (int unsigned k = 0; k < SPLIT; k++) begin
            if (vp[g*SPLIT + k] && !grp_any[g]) begin
               grp_any[g] = 1'b1;
               grp_idx[g] = WIDTH_LOG'(g*SPLIT + k);
            end
         end
      end
      for (int unsigned g = 0; g < NGRP; g++) begin
         if (grp_any[g] && !found) begin
            found = 1'b1;
            idx   = grp_idx[g];
         end
      end
      return {found, idx};
   endfunction

   logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0]     hi_mask;
   logic [WIDTH_LOG:0]   first_all, first_hi;
   logic                 found;
   logic [WIDTH_LOG-1:0] winner;
   logic [WIDTH-1:0]     win_oh;
   logic                 accept;

   // Round-robin search: the lowest requester at or above ptr wins; if there
   // is none, the search wraps and the lowest requester overall wins.
   always_comb begin
      hi_mask = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         hi_mask[i] = (WIDTH_LOG'(i) >= ptr_q);
      end
   end

   assign first_all = first_set(dec_vld);
   assign first_hi  = first_set(dec_vld & hi_mask);
   assign found     = first_all[WIDTH_LOG];
   assign winner    = (MODE == 1 && first_hi[WIDTH_LOG]) ? first_hi[WIDTH_LOG-1:0]
                                                         : first_all[WIDTH_LOG-1:0];

   always_comb begin
      win_oh = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         win_oh[i] = found && (winner == WIDTH_LOG'(i));
      end
   end

   // Explicit wrap keeps ptr inside 0..WIDTH-1 for non-power-of-2 WIDTH.
   always_comb begin
      ptr_d = ptr_q;
      if (MODE == 1 && accept) begin
         ptr_d = (winner == WIDTH_LOG'(WIDTH - 1)) ? '0 : winner + WIDTH_LOG'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   if (REGISTERED != 0) begin : g_reg
      logic                 vld_q, vld_d;
      logic [WIDTH_LOG-1:0] idx_q, idx_d;
      logic [WIDTH-1:0]     gnt_q, gnt_d;
      logic                 acc_rdy;

      // A new result may be loaded when the stage is empty or draining now.
      assign acc_rdy = !vld_q || enc_rdy;
      assign accept  = acc_rdy && found;

      always_comb begin
         vld_d = vld_q;
         idx_d = idx_q;
         gnt_d = '0;
         if (accept) begin
            vld_d = 1'b1;
            idx_d = winner;
            gnt_d = win_oh;
         end else if (enc_rdy) begin
            vld_d = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            idx_q <= '0;
            gnt_q <= '0;
         end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
            gnt_q <= gnt_d;
         end
      end

      assign enc_vld = vld_q;
      assign enc_idx = idx_q;
      assign dec_gnt = gnt_q;
   end else begin : g_comb
      assign accept  = found && enc_rdy;
      assign enc_vld = found;
      assign enc_idx = found ? winner : '0;
      assign dec_gnt = win_oh & {WIDTH{enc_rdy}};
   end

endmodule
